// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl
// Avalon-MM master that reads the system-ID slave (word 0 = system ID,
// word 1 = build timestamp), compares both words against values fixed at
// generation time and reports the result to the boot/health logic.
// Runs once after reset release (AUTO_START) and again on each start pulse.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset_n         in   synchronous active-low reset
//   start           in   single-cycle request to (re)run the check
//   avm_address     out  sysid word select (0 = ID, 1 = timestamp)
//   avm_read        out  read strobe
//   avm_waitrequest in   slave stall
//   avm_readdata    in   slave read data
//   busy            out  check in progress (RD_ID, RD_TS, CMP)
//   done            out  check finished, held until next start
//   pass            out  done and id_ok and ts_ok and no timeout
//   id_ok / ts_ok   out  captured word matches its expected value
//   timeout_err     out  a read stalled for TIMEOUT cycles
//   id_value        out  captured word 0
//   ts_value        out  captured word 1
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1417485996,
    parameter int unsigned TIMEOUT            = 16,
    parameter int unsigned AUTO_START         = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // A zero-width counter is illegal, so keep at least one bit when the
    // timeout is disabled.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CMP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          auto_q, auto_d;
    logic          read_q, read_d;
    logic          addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          id_ok_q, id_ok_d;
    logic          ts_ok_q, ts_ok_d;
    logic          tmo_q, tmo_d;
    logic [31:0]   id_q, id_d;
    logic [31:0]   ts_q, ts_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        done_d  = done_q;
        pass_d  = pass_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        tmo_d   = tmo_q;
        id_d    = id_q;
        ts_d    = ts_q;

        case (state_q)
            IDLE, DONE: begin
                // auto_q is only ever set while in IDLE after reset.
                if (start || auto_q) begin
                    state_d = RD_ID;
                    auto_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                if (!avm_waitrequest) begin
                    // A grant wins over a timeout reached in the same cycle.
                    if (state_q == RD_ID) begin
                        id_d    = avm_readdata;
                        state_d = RD_TS;
                    end else begin
                        ts_d    = avm_readdata;
                        state_d = CMP;
                    end
                    cnt_d = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                        pass_d  = 1'b0;
                        id_ok_d = 1'b0;
                        ts_ok_d = 1'b0;
                    end
                end
            end
            CMP: begin
                id_ok_d = (id_q == EXPECTED_ID);
                ts_ok_d = (ts_q == EXPECTED_TIMESTAMP);
                pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Bus and status outputs are registered from the next state so they
        // line up with the state register.
        read_d = (state_d == RD_ID) || (state_d == RD_TS);
        addr_d = (state_d == RD_TS);
        busy_d = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CMP);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            auto_q  <= (AUTO_START != 0);
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            tmo_q   <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            tmo_q   <= tmo_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = tmo_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with default parameters
// (EXPECTED_ID = 0, EXPECTED_TIMESTAMP = 1417485996, TIMEOUT = 16).
module tb_sysid_check_ctrl;

    localparam logic [31:0] TS_GOOD = 32'd1417485996;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    // Slave model controls
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall_cfg;
    logic        stuck_ts;
    int          stall_ctr = 0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sysid_check_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout_err    (timeout_err),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    // Simple slave: stalls stall_cfg cycles per read, or forever on word 1
    // when stuck_ts is set.
    assign avm_waitrequest = avm_read && ((stuck_ts && avm_address) || (stall_ctr < stall_cfg));
    assign avm_readdata    = avm_address ? ts_word : id_word;

    always @(posedge clock) begin
        if (!avm_read || !avm_waitrequest) stall_ctr <= 0;
        else                               stall_ctr <= stall_ctr + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".read"}, avm_read, 0);
        check({tag, ".addr"}, avm_address, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".id_ok"}, id_ok, 0);
        check({tag, ".ts_ok"}, ts_ok, 0);
        check({tag, ".tmo"}, timeout_err, 0);
        check({tag, ".id_value"}, id_value, 0);
        check({tag, ".ts_value"}, ts_value, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        id_word   = 32'd0;
        ts_word   = TS_GOOD;
        stall_cfg = 0;
        stuck_ts  = 1'b0;
        tick();
        tick();
        check_zero("reset");

        // 1: auto-start, zero-wait reads
        reset_n = 1'b1;
        tick();
        check("auto.e1.read", avm_read, 1);
        check("auto.e1.addr", avm_address, 0);
        check("auto.e1.busy", busy, 1);
        tick();
        check("auto.e2.read", avm_read, 1);
        check("auto.e2.addr", avm_address, 1);
        tick();
        check("auto.e3.read", avm_read, 0);
        check("auto.e3.busy", busy, 1);
        check("auto.e3.done", done, 0);
        tick();
        check("auto.e4.done", done, 1);
        check("auto.e4.busy", busy, 0);
        check("auto.e4.pass", pass, 1);
        check("auto.e4.id_ok", id_ok, 1);
        check("auto.e4.ts_ok", ts_ok, 1);
        check("auto.e4.ts_value", ts_value, TS_GOOD);
        check("auto.e4.id_value", id_value, 0);

        // 2: wrong timestamp
        ts_word = 32'h1234_5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("badts.e1.done", done, 0);
        check("badts.e1.pass", pass, 0);
        check("badts.e1.busy", busy, 1);
        tick();
        tick();
        check("badts.e3.done", done, 0);
        tick();
        check("badts.e4.done", done, 1);
        check("badts.e4.id_ok", id_ok, 1);
        check("badts.e4.ts_ok", ts_ok, 0);
        check("badts.e4.pass", pass, 0);
        check("badts.e4.ts_value", ts_value, 32'h1234_5678);

        // 3: 3 stall cycles per read
        ts_word   = TS_GOOD;
        stall_cfg = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall.e1.read", avm_read, 1);
        check("stall.e1.addr", avm_address, 0);
        for (int e = 2; e <= 8; e++) begin
            tick();
            check($sformatf("stall.e%0d.read", e), avm_read, 1);
            check($sformatf("stall.e%0d.addr", e), avm_address, (e >= 5) ? 1 : 0);
        end
        tick();
        check("stall.e9.read", avm_read, 0);
        check("stall.e9.done", done, 0);
        tick();
        check("stall.e10.done", done, 1);
        check("stall.e10.pass", pass, 1);
        check("stall.e10.ts_value", ts_value, TS_GOOD);

        // 4: timestamp read stuck -> timeout after 16 stalls
        stall_cfg = 0;
        stuck_ts  = 1'b1;
        id_word   = 32'hCAFE_BABE;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 2; e <= 17; e++) tick();
        check("tmo.e17.busy", busy, 1);
        check("tmo.e17.read", avm_read, 1);
        check("tmo.e17.addr", avm_address, 1);
        check("tmo.e17.done", done, 0);
        tick();
        check("tmo.e18.done", done, 1);
        check("tmo.e18.tmo", timeout_err, 1);
        check("tmo.e18.pass", pass, 0);
        check("tmo.e18.id_ok", id_ok, 0);
        check("tmo.e18.ts_ok", ts_ok, 0);
        check("tmo.e18.read", avm_read, 0);
        check("tmo.e18.busy", busy, 0);
        check("tmo.e18.id_value", id_value, 32'hCAFE_BABE);
        check("tmo.e18.ts_value", ts_value, TS_GOOD);

        // 5: start in DONE clears results; start during RD_TS is ignored
        stuck_ts = 1'b0;
        id_word  = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun.e1.done", done, 0);
        check("rerun.e1.tmo", timeout_err, 0);
        tick();
        check("rerun.e2.addr", avm_address, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rerun.e4.done", done, 1);
        check("rerun.e4.pass", pass, 1);
        tick();
        tick();
        check("rerun.e6.busy", busy, 0);
        check("rerun.e6.done", done, 1);
        check("rerun.e6.read", avm_read, 0);

        // 6: reset pulse in RD_ID, then auto-restart
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst.e1.read", avm_read, 1);
        reset_n = 1'b0;
        tick();
        check_zero("rst.mid");
        reset_n = 1'b1;
        tick();
        check("rst.r1.busy", busy, 1);
        tick();
        tick();
        tick();
        check("rst.r4.done", done, 1);
        check("rst.r4.pass", pass, 1);
        check("rst.r4.ts_value", ts_value, TS_GOOD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
